// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit common-anode 7-segment scanner with PWM brightness, dp/blank masks and frame-synchronous load.
// Optional leading-zero suppression when SEG7_LZ_SUPPRESS_EN is defined.
module seg7_scan_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned DIV_LOG2 = 16,
    localparam int unsigned IDX_W = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [4*N_DIGITS-1:0] x,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  load,
    input  logic [3:0]            bright,
    output logic                  pending,
    output logic                  frame_tick,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  dp
);

    logic [DIV_LOG2-1:0]   presc;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] sh_x, act_x;
    logic [N_DIGITS-1:0]   sh_dp, sh_blank, act_dp, act_blank;
    logic [N_DIGITS-1:0]   sup;

    logic slot_end, last_slot, frame_end, pwm_on;
    logic [3:0] cur_nib;
    logic cur_dp, cur_blank, cur_sup;
    logic [N_DIGITS-1:0] an_next;

    assign slot_end  = &presc;
    assign last_slot = (idx == IDX_W'(N_DIGITS - 1));
    assign frame_end = slot_end & last_slot;
    assign pwm_on    = (presc[DIV_LOG2-1 -: 4] <= bright);

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Prescaler and scan index; idx wraps explicitly for non-power-of-two digit counts
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc      <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            presc      <= presc + DIV_LOG2'(1);
            frame_tick <= frame_end;
            if (slot_end)
                idx <= last_slot ? '0 : idx + IDX_W'(1);
        end
    end

    // Shadow capture and frame-boundary commit; a coincident load commits the old shadow
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sh_x      <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_x     <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            pending   <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                act_x     <= sh_x;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
            end
            if (load) begin
                sh_x     <= x;
                sh_dp    <= dp_in;
                sh_blank <= blank;
                pending  <= 1'b1;
            end else if (frame_end) begin
                pending  <= 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    logic lead;
    // A digit is suppressed while it and every more significant digit are zero
    always_comb begin
        sup  = '0;
        lead = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lead   = lead & (act_x[4*i +: 4] == 4'h0);
            sup[i] = lead;
        end
    end
`else
    assign sup = '0;
`endif

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_sup   = 1'b0;
        an_next   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = act_x[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_blank  = act_blank[i];
                cur_sup    = sup[i];
                an_next[i] = ~pwm_on;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seg <= 7'h7F;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= (cur_blank | cur_sup) ? 7'h7F : decode(cur_nib);
            an  <= an_next;
            dp  <= cur_blank ? 1'b1 : ~cur_dp;
        end
    end

endmodule
